// File: rtl/npc_pkg.sv
// Shared integer-pipeline constants and the write-back request record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package npc_pkg;

    localparam int XLEN = 64;   // integer data width
    localparam int NREG = 32;   // architectural register count
    localparam int AW   = 5;    // register address width

    // One write-back request as presented by an execution unit.
    typedef struct packed {
        logic            valid;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regs_wb_arb.sv
// Two-way write-back arbiter (EXU vs LSU) with an alternating priority bit.
// Latency: grants are combinational from the valids; priority updates at the edge.
// Backpressure: the loser of a conflict waits exactly one cycle because priority flips on every conflict.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   i_exu_vld/i_lsu_vld  requester valids
//   o_exu_gnt/o_lsu_gnt  one-hot (or zero) grants
module regs_wb_arb (
    input  logic clk,
    input  logic rst_n,
    input  logic i_exu_vld,
    input  logic i_lsu_vld,
    output logic o_exu_gnt,
    output logic o_lsu_gnt
);

    logic r_prio_lsu;   // 1: LSU wins the next conflict
    logic w_conflict;

    assign w_conflict = i_exu_vld & i_lsu_vld;

    always_comb begin
        o_exu_gnt = i_exu_vld & (~i_lsu_vld | ~r_prio_lsu);
        o_lsu_gnt = i_lsu_vld & (~i_exu_vld |  r_prio_lsu);
    end

    // Only a real conflict moves the priority; sole requesters leave it alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prio_lsu <= 1'b1;
        end else if (w_conflict) begin
            r_prio_lsu <= ~r_prio_lsu;
        end
    end

endmodule

// File: rtl/regs_wb_sched.sv
// Write-back scheduler and RAW/WAW scoreboard for the 32x64 integer register file.
// Latency: transfer in cycle t drives the file write port in t+1; busy clears at the end of t+1.
// Backpressure: ready is the arbiter grant; the losing requester holds its request one cycle.
//
// Ports:
//   issue_*            IDU issue interface; issue_stall is combinational
//   exu_wb_*/lsu_wb_*  valid/ready write-back requests from EXU and LSU
//   wen/aind/din_REGS  registered register-file write port
//   busy               scoreboard bits, wb_err sticky write-to-idle-register flag
module regs_wb_sched
    import npc_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,

    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   issue_rs1,
    input  logic [AW-1:0]   issue_rs2,
    output logic            issue_stall,

    input  logic            exu_wb_valid,
    output logic            exu_wb_ready,
    input  logic [AW-1:0]   exu_wb_rd,
    input  logic [XLEN-1:0] exu_wb_data,

    input  logic            lsu_wb_valid,
    output logic            lsu_wb_ready,
    input  logic [AW-1:0]   lsu_wb_rd,
    input  logic [XLEN-1:0] lsu_wb_data,

    output logic            wen_REGS,
    output logic [AW-1:0]   aind_REGS,
    output logic [XLEN-1:0] din_REGS,

    output logic [NREG-1:0] busy,
    output logic            wb_err
);

    wb_req_t         w_exu_req;
    wb_req_t         w_lsu_req;
    logic            w_exu_gnt;
    logic            w_lsu_gnt;
    logic            w_xfer;
    logic [AW-1:0]   w_xfer_rd;
    logic [XLEN-1:0] w_xfer_data;
    logic            w_xfer_wr;
    logic            w_issue_acc;
    logic [NREG-1:0] w_busy_nxt;

    logic [NREG-1:0] r_busy;
    logic            r_wen;
    logic [AW-1:0]   r_aind;
    logic [XLEN-1:0] r_din;
    logic            r_wb_err;

    assign w_exu_req = '{valid: exu_wb_valid, rd: exu_wb_rd, data: exu_wb_data};
    assign w_lsu_req = '{valid: lsu_wb_valid, rd: lsu_wb_rd, data: lsu_wb_data};

    regs_wb_arb u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_exu_vld (w_exu_req.valid),
        .i_lsu_vld (w_lsu_req.valid),
        .o_exu_gnt (w_exu_gnt),
        .o_lsu_gnt (w_lsu_gnt)
    );

    // Grants are already qualified by valid, so ready == grant means transfer == grant.
    assign exu_wb_ready = w_exu_gnt;
    assign lsu_wb_ready = w_lsu_gnt;

    always_comb begin
        w_xfer      = w_exu_gnt | w_lsu_gnt;
        w_xfer_rd   = w_lsu_gnt ? w_lsu_req.rd   : w_exu_req.rd;
        w_xfer_data = w_lsu_gnt ? w_lsu_req.data : w_exu_req.data;
        // x0 write-backs are consumed but never reach the file.
        w_xfer_wr   = w_xfer & (w_xfer_rd != '0);
    end

    // Hazard check covers sources (RAW) and destination (WAW); unused fields are 0 and bit 0 is never busy.
    assign issue_stall = issue_valid &
                         (r_busy[issue_rs1] | r_busy[issue_rs2] | r_busy[issue_rd]);
    assign w_issue_acc = issue_valid & ~issue_stall;

    // Clear tracks the cycle the file actually writes; a same-register set is applied last so it wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_wen) begin
            w_busy_nxt[r_aind] = 1'b0;
        end
        if (w_issue_acc) begin
            w_busy_nxt[issue_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy   <= '0;
            r_wen    <= 1'b0;
            r_aind   <= '0;
            r_din    <= '0;
            r_wb_err <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_wen  <= w_xfer_wr;
            if (w_xfer_wr) begin
                r_aind <= w_xfer_rd;
                r_din  <= w_xfer_data;
            end
            // A write-back nobody is waiting for means the pipeline lost track of a register.
            if (w_xfer_wr && !r_busy[w_xfer_rd]) begin
                r_wb_err <= 1'b1;
            end
        end
    end

    assign busy      = r_busy;
    assign wen_REGS  = r_wen;
    assign aind_REGS = r_aind;
    assign din_REGS  = r_din;
    assign wb_err    = r_wb_err;

endmodule

// File: tb/tb_regs_wb_sched.sv
// Directed self-checking bench for regs_wb_sched.
// Latency: one table row per clock; comb outputs checked before the edge, registered outputs after it.
// Backpressure: requesters hold their requests across rows until granted.
module tb_regs_wb_sched;
    import npc_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd, issue_rs1, issue_rs2;
    logic            issue_stall;
    logic            exu_wb_valid, exu_wb_ready;
    logic [AW-1:0]   exu_wb_rd;
    logic [XLEN-1:0] exu_wb_data;
    logic            lsu_wb_valid, lsu_wb_ready;
    logic [AW-1:0]   lsu_wb_rd;
    logic [XLEN-1:0] lsu_wb_data;
    logic            wen_REGS;
    logic [AW-1:0]   aind_REGS;
    logic [XLEN-1:0] din_REGS;
    logic [NREG-1:0] busy;
    logic            wb_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regs_wb_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_rs1    (issue_rs1),
        .issue_rs2    (issue_rs2),
        .issue_stall  (issue_stall),
        .exu_wb_valid (exu_wb_valid),
        .exu_wb_ready (exu_wb_ready),
        .exu_wb_rd    (exu_wb_rd),
        .exu_wb_data  (exu_wb_data),
        .lsu_wb_valid (lsu_wb_valid),
        .lsu_wb_ready (lsu_wb_ready),
        .lsu_wb_rd    (lsu_wb_rd),
        .lsu_wb_data  (lsu_wb_data),
        .wen_REGS     (wen_REGS),
        .aind_REGS    (aind_REGS),
        .din_REGS     (din_REGS),
        .busy         (busy),
        .wb_err       (wb_err)
    );

    typedef struct {
        logic        rst_n;
        logic        iv;
        logic [4:0]  ird, irs1, irs2;
        logic        ev;
        logic [4:0]  erd;
        logic [63:0] edat;
        logic        lv;
        logic [4:0]  lrd;
        logic [63:0] ldat;
        logic        x_stall, x_erdy, x_lrdy;
        logic        x_wen;
        logic [4:0]  x_aind;
        logic [63:0] x_din;
        logic [31:0] x_busy;
        logic        x_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rst, input logic iv, input logic [4:0] ird, input logic [4:0] irs1,
        input logic [4:0] irs2, input logic ev, input logic [4:0] erd, input logic [63:0] edat,
        input logic lv, input logic [4:0] lrd, input logic [63:0] ldat,
        input logic xs, input logic xe, input logic xl, input logic xw, input logic [4:0] xa,
        input logic [63:0] xd, input logic [31:0] xb, input logic xr);
        vec_t v;
        v.rst_n = rst; v.iv = iv; v.ird = ird; v.irs1 = irs1; v.irs2 = irs2;
        v.ev = ev; v.erd = erd; v.edat = edat; v.lv = lv; v.lrd = lrd; v.ldat = ldat;
        v.x_stall = xs; v.x_erdy = xe; v.x_lrdy = xl; v.x_wen = xw; v.x_aind = xa;
        v.x_din = xd; v.x_busy = xb; v.x_err = xr;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d got=%0h want=%0h", nm, row, act, exp);
        end
    endtask

    localparam logic [63:0] DA = 64'hAAAA_0000_0000_000A;
    localparam logic [63:0] DB = 64'hBBBB_0000_0000_000B;
    localparam logic [63:0] DC = 64'hCCCC_0000_0000_000C;
    localparam logic [63:0] DD = 64'hDDDD_0000_0000_000D;
    localparam logic [63:0] DE = 64'hEEEE_0000_0000_000E;

    // Safety net: the bench must never hang.
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int ew, lw;

        //           rst iv ird rs1 rs2  ev erd edat     lv lrd ldat   stl erdy lrdy wen aind din      busy          err
        // Reset with both requesters active, then first post-reset conflict goes to LSU.
        tbl.push_back(mk(0, 0, 0, 0, 0,  1, 3, 64'h33, 1, 4, 64'h44, 0, 0, 0, 0, 0, 0,       32'h0,        0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  1, 3, 64'h33, 1, 4, 64'h44, 0, 0, 0, 0, 0, 0,       32'h0,        0));
        tbl.push_back(mk(1, 0, 0, 0, 0,  1, 0, 64'h11, 1, 0, 64'h22, 0, 0, 1, 0, 0, 0,       32'h0,        0));
        // RAW / WAW on x5.
        tbl.push_back(mk(1, 1, 5, 0, 0,  0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 0,       32'h20,       0));
        tbl.push_back(mk(1, 1, 0, 5, 0,  0, 0, 0,      0, 0, 0,      1, 0, 0, 0, 0, 0,       32'h20,       0));
        tbl.push_back(mk(1, 1, 5, 0, 0,  0, 0, 0,      0, 0, 0,      1, 0, 0, 0, 0, 0,       32'h20,       0));
        tbl.push_back(mk(1, 1, 0, 5, 0,  1, 5, 64'h1234, 0, 0, 0,    1, 1, 0, 1, 5, 64'h1234, 32'h20,      0));
        tbl.push_back(mk(1, 1, 0, 0, 5,  0, 0, 0,      0, 0, 0,      1, 0, 0, 0, 0, 0,       32'h0,        0));
        tbl.push_back(mk(1, 1, 0, 5, 0,  0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 0,       32'h0,        0));
        // x0 conflict: priority is now EXU; it wins and priority returns to LSU.
        tbl.push_back(mk(1, 0, 0, 0, 0,  1, 0, 64'h55, 1, 0, 64'h66, 0, 1, 0, 0, 0, 0,       32'h0,        0));
        // Mark x10..x14 busy.
        tbl.push_back(mk(1, 1, 10, 0, 0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 0,       32'h0400,     0));
        tbl.push_back(mk(1, 1, 11, 0, 0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 0,       32'h0C00,     0));
        tbl.push_back(mk(1, 1, 12, 0, 0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 0,       32'h1C00,     0));
        tbl.push_back(mk(1, 1, 13, 0, 0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 0,       32'h3C00,     0));
        tbl.push_back(mk(1, 1, 14, 0, 0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 0,       32'h7C00,     0));
        // Four conflict cycles: LSU, EXU, LSU, EXU; losers re-present unchanged.
        tbl.push_back(mk(1, 0, 0, 0, 0,  1, 10, DA,    1, 11, DB,    0, 0, 1, 1, 11, DB,     32'h7C00,     0));
        tbl.push_back(mk(1, 0, 0, 0, 0,  1, 10, DA,    1, 12, DC,    0, 1, 0, 1, 10, DA,     32'h7400,     0));
        tbl.push_back(mk(1, 0, 0, 0, 0,  1, 13, DD,    1, 12, DC,    0, 0, 1, 1, 12, DC,     32'h7000,     0));
        tbl.push_back(mk(1, 0, 0, 0, 0,  1, 13, DD,    1, 14, DE,    0, 1, 0, 1, 13, DD,     32'h6000,     0));
        tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0,      1, 14, DE,    0, 0, 1, 1, 14, DE,     32'h4000,     0));
        tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 0,       32'h0,        0));
        // x0 issue and x0 load write-back.
        tbl.push_back(mk(1, 1, 0, 0, 0,  0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 0,       32'h0,        0));
        tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0,      1, 0, 64'h99, 0, 0, 1, 0, 0, 0,       32'h0,        0));
        // Write-back to idle x7: write happens, error sticks.
        tbl.push_back(mk(1, 0, 0, 0, 0,  1, 7, 64'h77, 0, 0, 0,      0, 1, 0, 1, 7, 64'h77,  32'h0,        1));
        tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 0,       32'h0,        1));
        tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 0,       32'h0,        1));
        // Reset while a write to x9 is pending.
        tbl.push_back(mk(1, 1, 9, 0, 0,  0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 0,       32'h200,      1));
        tbl.push_back(mk(1, 0, 0, 0, 0,  1, 9, 64'h99, 0, 0, 0,      0, 1, 0, 1, 9, 64'h99,  32'h200,      1));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 0,       32'h0,        0));
        tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 0,       32'h0,        0));

        foreach (tbl[i]) begin
            @(negedge clk);
            rst_n        = tbl[i].rst_n;
            issue_valid  = tbl[i].iv;
            issue_rd     = tbl[i].ird;
            issue_rs1    = tbl[i].irs1;
            issue_rs2    = tbl[i].irs2;
            exu_wb_valid = tbl[i].ev;
            exu_wb_rd    = tbl[i].erd;
            exu_wb_data  = tbl[i].edat;
            lsu_wb_valid = tbl[i].lv;
            lsu_wb_rd    = tbl[i].lrd;
            lsu_wb_data  = tbl[i].ldat;
            #1;
            // Grants are undefined before the first reset edge, so comb checks run only out of reset.
            if (tbl[i].rst_n) begin
                chk("issue_stall", i, 64'(issue_stall), 64'(tbl[i].x_stall));
                chk("exu_wb_ready", i, 64'(exu_wb_ready), 64'(tbl[i].x_erdy));
                chk("lsu_wb_ready", i, 64'(lsu_wb_ready), 64'(tbl[i].x_lrdy));
            end
            @(posedge clk);
            #1;
            chk("wen_REGS", i, 64'(wen_REGS), 64'(tbl[i].x_wen));
            if (tbl[i].x_wen || !tbl[i].rst_n) begin
                chk("aind_REGS", i, 64'(aind_REGS), 64'(tbl[i].x_aind));
                chk("din_REGS", i, din_REGS, tbl[i].x_din);
            end
            chk("busy", i, 64'(busy), 64'(tbl[i].x_busy));
            chk("wb_err", i, 64'(wb_err), 64'(tbl[i].x_err));
        end

        // Hand sequence: conflict right after reset, loser wait must be exactly one cycle.
        @(negedge clk);
        issue_valid = 1'b1; issue_rd = 5'd20;
        @(negedge clk);
        issue_rd = 5'd21;
        @(negedge clk);
        issue_valid = 1'b0; issue_rd = 5'd0;
        exu_wb_rd = 5'd20; exu_wb_data = 64'hE20;
        lsu_wb_rd = 5'd21; lsu_wb_data = 64'hD21;
        ew = 99; lw = 99;
        for (int c = 0; c < 4; c++) begin
            if (c != 0) @(negedge clk);
            exu_wb_valid = (ew == 99);
            lsu_wb_valid = (lw == 99);
            #1;
            if (exu_wb_valid && exu_wb_ready) ew = c;
            if (lsu_wb_valid && lsu_wb_ready) lw = c;
        end
        @(negedge clk);
        exu_wb_valid = 1'b0; lsu_wb_valid = 1'b0;
        chk("lsu_wait", 0, 64'(lw), 64'd0);
        chk("exu_wait", 0, 64'(ew), 64'd1);
        repeat (3) @(negedge clk);
        chk("busy_drained", 0, 64'(busy), 64'd0);
        chk("wb_err_clean", 0, 64'(wb_err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
